// File: rtl/nibble_mult_seq.sv
// nibble_mult_seq
//   Multi-cycle unsigned multiplier sequencer. It accepts an operand pair of
//   4*N bits, walks all N*N nibble pairs through an external combinational
//   4x4 multiplier and accumulates the shifted 8-bit partial products into an
//   8*N-bit result. The result is returned over a valid/ready handshake.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high reset
//   io_in_valid   operand pair valid
//   io_in_ready   block can accept an operand pair (IDLE only)
//   io_in_a       multiplicand, 4*N bits, unsigned
//   io_in_b       multiplier, 4*N bits, unsigned
//   io_mul_lhs    nibble of a driven to the 4x4 multiplier
//   io_mul_rhs    nibble of b driven to the 4x4 multiplier
//   io_mul_prod   8-bit product returned combinationally by the 4x4 multiplier
//   io_out_valid  result valid (DONE state)
//   io_out_ready  downstream accepts result
//   io_out_data   registered product a*b, 8*N bits
module nibble_mult_seq #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [4*N-1:0]   io_in_a,
  input  logic [4*N-1:0]   io_in_b,
  output logic [3:0]       io_mul_lhs,
  output logic [3:0]       io_mul_rhs,
  input  logic [7:0]       io_mul_prod,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [8*N-1:0]   io_out_data
);

  localparam int W  = 4 * N;
  localparam int RW = 8 * N;
  // Nibble indices fit in 3 bits for every legal N (1..8).
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [RW-1:0] acc;
  logic [2:0]    i;
  logic [2:0]    j;

  logic          accept;
  logic          last_step;
  logic [3:0]    pos;
  logic [5:0]    shamt;
  logic [RW-1:0] term;

  // Partial product weight is 16^(i+j); the shift never exceeds the
  // accumulator width because i+j <= 2*(N-1).
  always_comb begin
    pos       = {1'b0, i} + {1'b0, j};
    shamt     = {pos, 2'b00};
    term      = RW'(io_mul_prod) << shamt;
    last_step = (i == LAST) && (j == LAST);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/multiplier outputs
  always_comb begin
    state_next   = state;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_mul_lhs   = 4'h0;
    io_mul_rhs   = 4'h0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        // State already reads IDLE while reset is held, so gate ready
        // explicitly to keep it low until reset is released.
        io_in_ready = ~reset;
        accept      = io_in_valid & ~reset;
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        io_mul_lhs = 4'(a_reg >> {i, 2'b00});
        io_mul_rhs = 4'(b_reg >> {j, 2'b00});
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, nibble counters and accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else if (accept) begin
      a_reg <= io_in_a;
      b_reg <= io_in_b;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else if (state == RUN) begin
      acc <= acc + term;
      if (last_step) begin
        i <= '0;
        j <= '0;
      end else if (j == LAST) begin
        j <= '0;
        i <= i + 3'd1;
      end else begin
        j <= j + 3'd1;
      end
    end
  end

  // Result stays on the accumulator register until the next accept clears it.
  assign io_out_data = acc;

endmodule

// File: tb/tb_nibble_mult_seq.sv
module tb_nibble_mult_seq;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [15:0] io_in_a;
  logic [15:0] io_in_b;
  logic [3:0]  io_mul_lhs;
  logic [3:0]  io_mul_rhs;
  logic [7:0]  io_mul_prod;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_data;

  int vectors;
  int miscompares;

  nibble_mult_seq #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_mul_lhs   (io_mul_lhs),
    .io_mul_rhs   (io_mul_rhs),
    .io_mul_prod  (io_mul_prod),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_data  (io_out_data)
  );

  // External 4x4 lookup multiplier stand-in.
  assign io_mul_prod = 8'(io_mul_lhs) * 8'(io_mul_rhs);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction with io_out_ready held high; checks latency,
  // the nibble walk order, the product and the one-cycle valid pulse.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] p, input string tag);
    int n;
    logic [3:0] lhs_log[16];
    logic [3:0] rhs_log[16];
    n = 0;
    while (io_in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " in_ready"}, 64'(io_in_ready), 64'd1);
    io_out_ready = 1'b1;
    io_in_valid  = 1'b1;
    io_in_a      = a;
    io_in_b      = b;
    @(posedge clk); #1;
    io_in_valid = 1'b0;
    io_in_a     = 16'($urandom);
    io_in_b     = 16'($urandom);
    n = 0;
    while (io_out_valid !== 1'b1 && n < 100) begin
      if (n < 16) begin
        lhs_log[n] = io_mul_lhs;
        rhs_log[n] = io_mul_rhs;
      end
      @(posedge clk); #1; n++;
    end
    check({tag, " latency"}, 64'(n), 64'd16);
    check({tag, " product"}, 64'(io_out_data), 64'(p));
    check({tag, " no accept in DONE"}, 64'(io_in_ready), 64'd0);
    for (int t = 0; t < 16; t++) begin
      check($sformatf("%s lhs t=%0d", tag, t), 64'(lhs_log[t]), 64'(4'(a >> (4 * (t / N)))));
      check($sformatf("%s rhs t=%0d", tag, t), 64'(rhs_log[t]), 64'(4'(b >> (4 * (t % N)))));
    end
    @(posedge clk); #1;
    check({tag, " valid one cycle"}, 64'(io_out_valid), 64'd0);
    check({tag, " back to idle"}, 64'(io_in_ready), 64'd1);
    check({tag, " result held"}, 64'(io_out_data), 64'(p));
  endtask

  initial begin
    int   n;
    logic seen;
    logic [15:0] ra;
    logic [15:0] rb;

    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{16'h1234, 16'h5678, 32'h06260060};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[2] = '{16'h4321, 16'h8765, 32'h2380E305};
    tbl[3] = '{16'h0000, 16'hABCD, 32'h00000000};
    tbl[4] = '{16'h0007, 16'h0009, 32'h0000003F};
    tbl[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    tbl[6] = '{16'h00FF, 16'h0100, 32'h0000FF00};
    tbl[7] = '{16'h8000, 16'h0002, 32'h00010000};

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_out_ready = 1'b1;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    check("ready low in reset", 64'(io_in_ready), 64'd0);
    check("valid low in reset", 64'(io_out_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("ready after reset", 64'(io_in_ready), 64'd1);
    check("valid after reset", 64'(io_out_valid), 64'd0);
    check("data after reset", 64'(io_out_data), 64'd0);
    check("lhs after reset", 64'(io_mul_lhs), 64'd0);
    check("rhs after reset", 64'(io_mul_rhs), 64'd0);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      run_op(tbl[k].a, tbl[k].b, tbl[k].p, $sformatf("tbl%0d", k));
    end

    // Randomized operands against a*b
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 32'(ra) * 32'(rb), $sformatf("rnd%0d", k));
    end

    // Back-pressure: result held while io_out_ready is low
    io_out_ready = 1'b0;
    io_in_valid  = 1'b1;
    io_in_a      = 16'h0007;
    io_in_b      = 16'h0009;
    @(posedge clk); #1;
    io_in_a = 16'hFFFF;
    io_in_b = 16'hFFFF;
    n = 0;
    while (io_out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("bp latency", 64'(n), 64'd16);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp valid c%0d", k), 64'(io_out_valid), 64'd1);
      check($sformatf("bp data c%0d", k), 64'(io_out_data), 64'h3F);
      check($sformatf("bp ready c%0d", k), 64'(io_in_ready), 64'd0);
      @(posedge clk); #1;
    end
    io_out_ready = 1'b1;
    @(posedge clk); #1;
    io_in_valid = 1'b0;
    check("bp release valid", 64'(io_out_valid), 64'd0);
    check("bp release idle", 64'(io_in_ready), 64'd1);
    check("bp release data", 64'(io_out_data), 64'h3F);
    @(posedge clk); #1;
    check("bp nothing accepted", 64'(io_in_ready), 64'd1);

    // Reset pulse in the middle of RUN
    io_in_valid = 1'b1;
    io_in_a     = 16'h1234;
    io_in_b     = 16'h5678;
    @(posedge clk); #1;
    io_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort lhs t=8", 64'(io_mul_lhs), 64'h2);
    check("abort rhs t=8", 64'(io_mul_rhs), 64'h8);
    reset = 1'b1;
    #1;
    check("abort ready", 64'(io_in_ready), 64'd0);
    check("abort valid", 64'(io_out_valid), 64'd0);
    check("abort acc", 64'(io_out_data), 64'd0);
    check("abort lhs", 64'(io_mul_lhs), 64'd0);
    reset = 1'b0;
    #1;
    check("abort idle", 64'(io_in_ready), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (io_out_valid === 1'b1) seen = 1'b1;
    end
    check("abort no result", 64'(seen), 64'd0);
    run_op(16'h0000, 16'hABCD, 32'h0, "zero after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
